// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port RAM.
// Data requests win ties; exactly one RAM transaction is outstanding at a time.
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_inst,
  input  logic        dm_req_valid,
  input  logic        dm_req_wen,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  output logic        dm_req_ready,
  output logic        dm_rsp_valid,
  output logic [63:0] dm_rsp_rdata,
  output logic        ram_req_valid,
  input  logic        ram_req_ready,
  output logic        ram_req_wen,
  output logic [63:0] ram_req_addr,
  output logic [63:0] ram_req_wdata,
  output logic [7:0]  ram_req_wmask,
  input  logic        ram_rsp_valid,
  input  logic [63:0] ram_rsp_rdata,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    WAIT_I = 3'd2,
    REQ_D  = 3'd3,
    WAIT_D = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [63:0] lat_addr;
  logic        lat_wen;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_wmask;

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; RAM responses carry no back-pressure and are sampled only in WAIT_x.
  assign dm_req_ready = (state == IDLE) && !reset;
  assign if_req_ready = (state == IDLE) && !reset && !dm_req_valid;
  assign busy         = (state != IDLE);
  assign fsm_state    = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dm_req_valid)      state_next = REQ_D;
        else if (if_req_valid) state_next = REQ_I;
      end
      REQ_I:  if (ram_req_ready) state_next = WAIT_I;
      WAIT_I: if (ram_rsp_valid) state_next = IDLE;
      REQ_D:  if (ram_req_ready) state_next = WAIT_D;
      WAIT_D: if (ram_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wen   <= 1'b0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (state == IDLE) begin
      if (dm_req_valid) begin
        lat_addr  <= dm_req_addr;
        lat_wen   <= dm_req_wen;
        lat_wdata <= dm_req_wdata;
        lat_wmask <= dm_req_wmask;
      end else if (if_req_valid) begin
        lat_addr  <= if_req_addr;
        lat_wen   <= 1'b0;
        lat_wdata <= '0;
        lat_wmask <= '0;
      end
    end
  end

  always_comb begin
    ram_req_valid = 1'b0;
    ram_req_wen   = 1'b0;
    ram_req_addr  = '0;
    ram_req_wdata = '0;
    ram_req_wmask = '0;
    if (state == REQ_I) begin
      ram_req_valid = 1'b1;
      ram_req_addr  = {lat_addr[63:3], 3'b000};
    end else if (state == REQ_D) begin
      ram_req_valid = 1'b1;
      ram_req_wen   = lat_wen;
      ram_req_addr  = lat_addr;
      ram_req_wdata = lat_wdata;
      ram_req_wmask = lat_wmask;
    end
  end

  // Fetch returns the 32-bit half of the doubleword selected by address bit 2.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rsp_valid <= 1'b0;
      dm_rsp_valid <= 1'b0;
      if_rsp_inst  <= '0;
      dm_rsp_rdata <= '0;
    end else begin
      if_rsp_valid <= (state == WAIT_I) && ram_rsp_valid;
      dm_rsp_valid <= (state == WAIT_D) && ram_rsp_valid;
      if ((state == WAIT_I) && ram_rsp_valid)
        if_rsp_inst <= lat_addr[2] ? ram_rsp_rdata[63:32] : ram_rsp_rdata[31:0];
      if ((state == WAIT_D) && ram_rsp_valid)
        dm_rsp_rdata <= ram_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, stalled store, spurious
// response and mid-transaction reset scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_I  = 3'd1;
  localparam logic [2:0] S_WAIT_I = 3'd2;
  localparam logic [2:0] S_REQ_D  = 3'd3;
  localparam logic [2:0] S_WAIT_D = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        dm_req_valid;
  logic        dm_req_wen;
  logic [63:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [63:0] dm_rsp_rdata;
  logic        ram_req_valid;
  logic        ram_req_ready;
  logic        ram_req_wen;
  logic [63:0] ram_req_addr;
  logic [63:0] ram_req_wdata;
  logic [7:0]  ram_req_wmask;
  logic        ram_rsp_valid;
  logic [63:0] ram_rsp_rdata;
  logic        busy;
  logic [2:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  int ram_hs   = 0;
  int dm_pulses = 0;
  int if_pulses = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst),
    .dm_req_valid(dm_req_valid), .dm_req_wen(dm_req_wen), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
    .ram_req_valid(ram_req_valid), .ram_req_ready(ram_req_ready), .ram_req_wen(ram_req_wen),
    .ram_req_addr(ram_req_addr), .ram_req_wdata(ram_req_wdata), .ram_req_wmask(ram_req_wmask),
    .ram_rsp_valid(ram_rsp_valid), .ram_rsp_rdata(ram_rsp_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / event counters
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_req_valid && ram_req_ready) ram_hs++;
    if (dm_rsp_valid) dm_pulses++;
    if (if_rsp_valid) if_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  int hs_base;
  int dm_base;
  int if_base;

  initial begin
    reset = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 64'h0;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = '0;
    dm_req_wdata = '0; dm_req_wmask = '0;
    ram_req_ready = 1'b0; ram_rsp_valid = 1'b0; ram_rsp_rdata = '0;

    // reset: readies held low while reset is high
    drive_edge(); drive_edge();
    sample();
    check("rst_dm_ready", dm_req_ready, 0);
    dm_req_valid = 1'b0;
    #1;
    sample();
    check("rst_if_ready", if_req_ready, 0);
    drive_edge();
    reset = 1'b0; if_req_valid = 1'b0;
    sample();
    check("rst_state", fsm_state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_ram_valid", ram_req_valid, 0);
    check("rst_if_rsp_valid", if_rsp_valid, 0);
    check("rst_dm_rsp_valid", dm_rsp_valid, 0);
    check("rst_if_inst", if_rsp_inst, 0);
    check("rst_dm_rdata", dm_rsp_rdata, 0);
    check("idle_dm_ready", dm_req_ready, 1);

    // fetch at 0x80000004, RAM ready at once, response next cycle
    drive_edge();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0004; ram_req_ready = 1'b1;
    sample();
    check("f1_if_ready", if_req_ready, 1);
    drive_edge();
    if_req_valid = 1'b0;
    sample();
    check("f1_state_req", fsm_state, S_REQ_I);
    check("f1_ram_valid", ram_req_valid, 1);
    check("f1_ram_addr", ram_req_addr, 64'h8000_0000);
    check("f1_ram_wen", ram_req_wen, 0);
    check("f1_ram_wmask", ram_req_wmask, 0);
    check("f1_ram_wdata", ram_req_wdata, 0);
    check("f1_busy", busy, 1);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h0000_0013_0010_0093;
    sample();
    check("f1_state_wait", fsm_state, S_WAIT_I);
    check("f1_ram_valid_wait", ram_req_valid, 0);
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("f1_rsp_valid", if_rsp_valid, 1);
    check("f1_inst", if_rsp_inst, 64'h0000_0013);
    check("f1_busy_done", busy, 0);
    drive_edge();
    sample();
    check("f1_rsp_pulse_end", if_rsp_valid, 0);
    check("f1_inst_hold", if_rsp_inst, 64'h0000_0013);

    // simultaneous fetch and load: load first, fetch accepted on dm_rsp_valid cycle
    drive_edge();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0000;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = 64'h8000_1000;
    sample();
    check("p_dm_ready", dm_req_ready, 1);
    check("p_if_ready", if_req_ready, 0);
    drive_edge();
    dm_req_valid = 1'b0;
    sample();
    check("p_state_reqd", fsm_state, S_REQ_D);
    check("p_ram_addr_d", ram_req_addr, 64'h8000_1000);
    check("p_if_ready_busy", if_req_ready, 0);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h1122_3344_5566_7788;
    sample();
    check("p_state_waitd", fsm_state, S_WAIT_D);
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("p_dm_rsp_valid", dm_rsp_valid, 1);
    check("p_dm_rdata", dm_rsp_rdata, 64'h1122_3344_5566_7788);
    check("p_if_ready_c3", if_req_ready, 1);
    drive_edge();
    if_req_valid = 1'b0;
    sample();
    check("p_state_reqi", fsm_state, S_REQ_I);
    check("p_ram_addr_i", ram_req_addr, 64'h8000_0000);
    check("p_dm_pulse_end", dm_rsp_valid, 0);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    sample();
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("p_if_rsp_valid", if_rsp_valid, 1);
    check("p_if_inst", if_rsp_inst, 64'hBBBB_BBBB);
    check("p_dm_rdata_hold", dm_rsp_rdata, 64'h1122_3344_5566_7788);

    // store with RAM stalled 4 cycles; inputs scrambled after acceptance
    drive_edge();
    hs_base = ram_hs; dm_base = dm_pulses;
    ram_req_ready = 1'b0;
    dm_req_valid = 1'b1; dm_req_wen = 1'b1; dm_req_addr = 64'h8000_2008;
    dm_req_wdata = 64'hDEAD_BEEF_0000_0000; dm_req_wmask = 8'hF0;
    drive_edge();
    dm_req_valid = 1'b0; dm_req_wen = 1'b0; dm_req_addr = 64'h1234;
    dm_req_wdata = 64'h0; dm_req_wmask = 8'h0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("s_ram_valid", ram_req_valid, 1);
      check("s_ram_addr", ram_req_addr, 64'h8000_2008);
      check("s_ram_wdata", ram_req_wdata, 64'hDEAD_BEEF_0000_0000);
      check("s_ram_wmask", ram_req_wmask, 8'hF0);
      check("s_ram_wen", ram_req_wen, 1);
      if (i < 3) drive_edge();
    end
    // release the RAM; a coincident response on the handshake edge must be ignored
    drive_edge();
    ram_req_ready = 1'b1; ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h5555_5555_5555_5555;
    sample();
    check("s_state_reqd", fsm_state, S_REQ_D);
    drive_edge();
    ram_req_ready = 1'b0; ram_rsp_valid = 1'b0;
    sample();
    check("s_state_waitd", fsm_state, S_WAIT_D);
    check("s_no_early_rsp", dm_rsp_valid, 0);
    drive_edge();
    sample();
    check("s_wait_held", fsm_state, S_WAIT_D);
    check("s_wait_no_rsp", dm_rsp_valid, 0);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h0000_0000_CAFE_F00D;
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("s_dm_rsp_valid", dm_rsp_valid, 1);
    check("s_dm_rdata", dm_rsp_rdata, 64'h0000_0000_CAFE_F00D);
    drive_edge();
    sample();
    check("s_one_handshake", ram_hs - hs_base, 1);
    check("s_one_dm_pulse", dm_pulses - dm_base, 1);

    // spurious RAM response while idle
    dm_base = dm_pulses; if_base = if_pulses;
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h9999_9999_9999_9999;
    sample();
    check("sp_state", fsm_state, S_IDLE);
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("sp_busy", busy, 0);
    check("sp_no_dm_pulse", dm_pulses - dm_base, 0);
    check("sp_no_if_pulse", if_pulses - if_base, 0);
    check("sp_rdata_hold", dm_rsp_rdata, 64'h0000_0000_CAFE_F00D);

    // reset while in WAIT_D, RAM answers one cycle after release
    drive_edge();
    dm_base = dm_pulses;
    ram_req_ready = 1'b1;
    dm_req_valid = 1'b1; dm_req_wen = 1'b0; dm_req_addr = 64'h8000_3000;
    drive_edge();
    dm_req_valid = 1'b0;
    drive_edge();
    sample();
    check("r_state_waitd", fsm_state, S_WAIT_D);
    drive_edge();
    reset = 1'b1;
    sample();
    check("r_dm_ready_in_reset", dm_req_ready, 0);
    drive_edge();
    reset = 1'b0;
    sample();
    check("r_busy", busy, 0);
    check("r_state_idle", fsm_state, S_IDLE);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h7777_7777_7777_7777;
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("r_no_dm_pulse", dm_pulses - dm_base, 0);
    check("r_rdata_cleared", dm_rsp_rdata, 0);
    check("r_busy_after", busy, 0);

    // subsequent fetch at 0x80000008 completes normally (lower word)
    drive_edge();
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0008;
    drive_edge();
    if_req_valid = 1'b0;
    sample();
    check("r_fetch_addr", ram_req_addr, 64'h8000_0008);
    drive_edge();
    ram_rsp_valid = 1'b1; ram_rsp_rdata = 64'h0102_0304_0506_0708;
    drive_edge();
    ram_rsp_valid = 1'b0;
    sample();
    check("r_fetch_valid", if_rsp_valid, 1);
    check("r_fetch_inst", if_rsp_inst, 64'h0506_0708);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit
  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
